// File: rtl/ristretto_lsu_dmem_ctrl.sv
// Load/store data-memory controller: issues lane-aligned dmem requests, tracks up to
// MAX_OUTST in-order transactions and returns extended load data or local error responses.
module ristretto_lsu_dmem_ctrl #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MAX_OUTST = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_op_i,
    input  logic [1:0]          req_size_i,
    input  logic                req_unsigned_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    output logic                rsp_valid_o,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_store_o,
    output logic                rsp_err_o,
    output logic                rsp_misaligned_o,
    output logic                dmem_req_valid_o,
    input  logic                dmem_req_ready_i,
    output logic                dmem_we_o,
    output logic [ADDR_W-1:0]   dmem_addr_o,
    output logic [DATA_W/8-1:0] dmem_be_o,
    output logic [DATA_W-1:0]   dmem_wdata_o,
    input  logic                dmem_rsp_valid_i,
    input  logic [DATA_W-1:0]   dmem_rdata_i,
    input  logic                dmem_rsp_err_i
);
    localparam int OFF_W  = $clog2(DATA_W / 8);
    localparam int BE_W   = DATA_W / 8;
    localparam int META_W = OFF_W + 4;
    localparam int CNT_W  = $clog2(MAX_OUTST + 1);
    localparam int PTR_W  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam logic [CNT_W:0]   MaxOcc  = (CNT_W + 1)'(MAX_OUTST);
    localparam logic [PTR_W-1:0] LastPtr = PTR_W'(MAX_OUTST - 1);

    localparam logic [1:0] SzDouble = 2'b00;
    localparam logic [1:0] SzWord   = 2'b01;
    localparam logic [1:0] SzHalf   = 2'b10;
    localparam logic [1:0] SzByte   = 2'b11;

    typedef enum logic [1:0] {StIdle, StWrdy, StErr} state_e;

    state_e              state_q, state_d;
    logic                init_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic [META_W-1:0]   meta_q, meta_d;
    logic                err_mis_q, err_mis_d;
    logic                err_rsp_q, err_rsp_d;
    logic                err_rsp_mis_q, err_rsp_mis_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [META_W-1:0]   fifo_q [MAX_OUTST];

    logic                req_illegal, req_misal, req_bad, accept, hs, pop;
    logic [BE_W-1:0]     size_mask;
    logic [DATA_W-1:0]   wdata_rep, shifted, ext;
    logic [CNT_W:0]      occ;
    logic [OFF_W-1:0]    h_off;
    logic [1:0]          h_size;
    logic                h_uns, h_we;

    always_comb begin
        req_illegal = (req_size_i == SzDouble) && (DATA_W == 32);
        req_misal   = 1'b0;
        size_mask   = '0;
        wdata_rep   = req_wdata_i;
        unique case (req_size_i)
            SzByte: begin
                size_mask = BE_W'(8'h01);
                wdata_rep = {BE_W{req_wdata_i[7:0]}};
            end
            SzHalf: begin
                req_misal = req_addr_i[0];
                size_mask = BE_W'(8'h03);
                wdata_rep = {(BE_W / 2){req_wdata_i[15:0]}};
            end
            SzWord: begin
                req_misal = |req_addr_i[1:0];
                size_mask = BE_W'(8'h0F);
                wdata_rep = {(BE_W / 4){req_wdata_i[31:0]}};
            end
            default: begin
                req_misal = |req_addr_i[2:0];
                size_mask = BE_W'(8'hFF);
            end
        endcase
        req_bad = req_illegal || req_misal;
    end

    assign dmem_req_valid_o = (state_q == StWrdy);
    assign dmem_we_o        = we_q;
    assign dmem_addr_o      = addr_q;
    assign dmem_be_o        = be_q;
    assign dmem_wdata_o     = wdata_q;
    assign hs               = dmem_req_valid_o && dmem_req_ready_i;
    assign occ              = {1'b0, count_q} + {{CNT_W{1'b0}}, (state_q == StWrdy)};

    // Local error responses only start from an empty pipeline so they cannot overtake loads.
    assign req_ready_o = init_q && (state_q != StErr)
                      && !((state_q == StWrdy) && !dmem_req_ready_i)
                      && (occ < MaxOcc)
                      && (!req_bad || ((count_q == '0) && (state_q == StIdle)));
    assign accept = req_valid_i && req_ready_o;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        we_d          = we_q;
        meta_d        = meta_q;
        err_mis_d     = err_mis_q;
        err_rsp_d     = (state_q == StErr);
        err_rsp_mis_d = err_mis_q;
        if (state_q == StErr) begin
            state_d = StIdle;
        end else if (accept && req_bad) begin
            state_d   = StErr;
            err_mis_d = req_misal && !req_illegal;
        end else if (accept) begin
            state_d = StWrdy;
            addr_d  = {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            be_d    = size_mask << req_addr_i[OFF_W-1:0];
            wdata_d = wdata_rep;
            we_d    = req_op_i;
            meta_d  = {req_addr_i[OFF_W-1:0], req_size_i, req_unsigned_i, req_op_i};
        end else if (hs) begin
            state_d = StIdle;
        end
    end

    assign pop = dmem_rsp_valid_i && (count_q != '0);
    assign {h_off, h_size, h_uns, h_we} = fifo_q[rd_ptr_q];
    assign shifted = dmem_rdata_i >> {h_off, 3'b000};

    always_comb begin
        unique case (h_size)
            SzByte:  ext = h_uns ? DATA_W'(shifted[7:0])  : DATA_W'($signed(shifted[7:0]));
            SzHalf:  ext = h_uns ? DATA_W'(shifted[15:0]) : DATA_W'($signed(shifted[15:0]));
            SzWord:  ext = h_uns ? DATA_W'(shifted[31:0]) : DATA_W'($signed(shifted[31:0]));
            default: ext = shifted;
        endcase
    end

    assign rsp_valid_o      = pop || err_rsp_q;
    assign rsp_err_o        = err_rsp_q || (pop && dmem_rsp_err_i);
    assign rsp_misaligned_o = err_rsp_q && err_rsp_mis_q;
    assign rsp_store_o      = pop && h_we;
    assign rsp_rdata_o      = (pop && !dmem_rsp_err_i && !h_we) ? ext : '0;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (hs) begin
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (hs && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!hs && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            init_q        <= 1'b0;
            addr_q        <= '0;
            be_q          <= '0;
            wdata_q       <= '0;
            we_q          <= 1'b0;
            meta_q        <= '0;
            err_mis_q     <= 1'b0;
            err_rsp_q     <= 1'b0;
            err_rsp_mis_q <= 1'b0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            init_q        <= 1'b1;
            addr_q        <= addr_d;
            be_q          <= be_d;
            wdata_q       <= wdata_d;
            we_q          <= we_d;
            meta_q        <= meta_d;
            err_mis_q     <= err_mis_d;
            err_rsp_q     <= err_rsp_d;
            err_rsp_mis_q <= err_rsp_mis_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (hs) begin
            fifo_q[wr_ptr_q] <= meta_q;
        end
    end

endmodule

// File: tb/tb_ristretto_lsu_dmem_ctrl.sv
// Directed bench for ristretto_lsu_dmem_ctrl: 32-bit instance with a response scoreboard,
// plus a 64-bit instance for double-word and wide-lane checks.
module tb_ristretto_lsu_dmem_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        a_req_valid, a_req_ready, a_req_op, a_req_uns;
    logic [1:0]  a_req_size;
    logic [31:0] a_req_addr, a_req_wdata;
    logic        a_rsp_valid, a_rsp_store, a_rsp_err, a_rsp_mis;
    logic [31:0] a_rsp_rdata;
    logic        a_dv, a_dr, a_we, a_drv, a_derr;
    logic [31:0] a_daddr, a_dwdata, a_drdata;
    logic [3:0]  a_be;

    logic        b_req_valid, b_req_ready, b_req_op, b_req_uns;
    logic [1:0]  b_req_size;
    logic [31:0] b_req_addr;
    logic [63:0] b_req_wdata;
    logic        b_rsp_valid, b_rsp_store, b_rsp_err, b_rsp_mis;
    logic [63:0] b_rsp_rdata;
    logic        b_dv, b_dr, b_we, b_drv, b_derr;
    logic [31:0] b_daddr;
    logic [63:0] b_dwdata, b_drdata;
    logic [7:0]  b_be;

    ristretto_lsu_dmem_ctrl #(.DATA_W(32), .ADDR_W(32), .MAX_OUTST(2)) dut32 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_op_i(a_req_op),
        .req_size_i(a_req_size), .req_unsigned_i(a_req_uns), .req_addr_i(a_req_addr),
        .req_wdata_i(a_req_wdata), .rsp_valid_o(a_rsp_valid), .rsp_rdata_o(a_rsp_rdata),
        .rsp_store_o(a_rsp_store), .rsp_err_o(a_rsp_err), .rsp_misaligned_o(a_rsp_mis),
        .dmem_req_valid_o(a_dv), .dmem_req_ready_i(a_dr), .dmem_we_o(a_we),
        .dmem_addr_o(a_daddr), .dmem_be_o(a_be), .dmem_wdata_o(a_dwdata),
        .dmem_rsp_valid_i(a_drv), .dmem_rdata_i(a_drdata), .dmem_rsp_err_i(a_derr)
    );

    ristretto_lsu_dmem_ctrl #(.DATA_W(64), .ADDR_W(32), .MAX_OUTST(2)) dut64 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_op_i(b_req_op),
        .req_size_i(b_req_size), .req_unsigned_i(b_req_uns), .req_addr_i(b_req_addr),
        .req_wdata_i(b_req_wdata), .rsp_valid_o(b_rsp_valid), .rsp_rdata_o(b_rsp_rdata),
        .rsp_store_o(b_rsp_store), .rsp_err_o(b_rsp_err), .rsp_misaligned_o(b_rsp_mis),
        .dmem_req_valid_o(b_dv), .dmem_req_ready_i(b_dr), .dmem_we_o(b_we),
        .dmem_addr_o(b_daddr), .dmem_be_o(b_be), .dmem_wdata_o(b_dwdata),
        .dmem_rsp_valid_i(b_drv), .dmem_rdata_i(b_drdata), .dmem_rsp_err_i(b_derr)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        store;
        logic        err;
        logic        mis;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic saw_rsp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_rsp(input logic [31:0] rd, input logic st, input logic er,
                              input logic mi);
        exp_t e;
        e.rdata = rd;
        e.store = st;
        e.err   = er;
        e.mis   = mi;
        sb_q.push_back(e);
    endtask

    // Advance one cycle; responses of the 32-bit instance are scored at the falling edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        saw_rsp = a_rsp_valid;
        if (a_rsp_valid) begin
            check("rsp_has_expectation", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("rsp_rdata", a_rsp_rdata, e.rdata);
                check("rsp_store", a_rsp_store, e.store);
                check("rsp_err", a_rsp_err, e.err);
                check("rsp_misaligned", a_rsp_mis, e.mis);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic op, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        a_req_valid = 1'b1;
        a_req_op    = op;
        a_req_size  = sz;
        a_req_uns   = uns;
        a_req_addr  = addr;
        a_req_wdata = wd;
        check("req_ready_at_issue", a_req_ready, 1'b1);
        tick();
        a_req_valid = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rd, input logic er);
        a_drv    = 1'b1;
        a_drdata = rd;
        a_derr   = er;
        tick();
        a_drv    = 1'b0;
        a_derr   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        {a_req_valid, a_req_op, a_req_uns, a_drv, a_derr} = '0;
        a_req_size = 2'b00; a_req_addr = '0; a_req_wdata = '0; a_drdata = '0; a_dr = 1'b1;
        {b_req_valid, b_req_op, b_req_uns, b_drv, b_derr} = '0;
        b_req_size = 2'b00; b_req_addr = '0; b_req_wdata = '0; b_drdata = '0; b_dr = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("reset_rsp_valid", a_rsp_valid, 1'b0);
        check("reset_dmem_valid", a_dv, 1'b0);
        check("reset_dmem_addr", a_daddr, 32'h0);
        check("reset_dmem_be", a_be, 4'h0);
        rst_n = 1'b1;
        tick();
        tick();
        check("ready_after_reset", a_req_ready, 1'b1);

        // Signed and unsigned byte loads from the top lane.
        issue(1'b0, 2'b11, 1'b0, 32'h1003, 32'h0);
        check("lb_dmem_valid", a_dv, 1'b1);
        check("lb_addr", a_daddr, 32'h1000);
        check("lb_be", a_be, 4'b1000);
        check("lb_we", a_we, 1'b0);
        expect_rsp(32'hFFFF_FF80, 1'b0, 1'b0, 1'b0);
        tick();
        respond(32'h80AB_CDEF, 1'b0);
        check("lb_rsp_seen", saw_rsp, 1'b1);
        issue(1'b0, 2'b11, 1'b1, 32'h1003, 32'h0);
        expect_rsp(32'h0000_0080, 1'b0, 1'b0, 1'b0);
        tick();
        respond(32'h80AB_CDEF, 1'b0);

        // Half store with lane replication.
        issue(1'b1, 2'b10, 1'b0, 32'h2002, 32'h1234_BEEF);
        check("sh_addr", a_daddr, 32'h2000);
        check("sh_be", a_be, 4'b1100);
        check("sh_wdata", a_dwdata, 32'hBEEF_BEEF);
        check("sh_we", a_we, 1'b1);
        expect_rsp(32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        respond(32'hDEAD_BEEF, 1'b0);

        // Misaligned word: no dmem request, error exactly two cycles after the request.
        expect_rsp(32'h0, 1'b0, 1'b1, 1'b1);
        issue(1'b0, 2'b01, 1'b0, 32'h3001, 32'h0);
        check("mis_no_dmem_c1", a_dv, 1'b0);
        tick();
        check("mis_no_rsp_c1", saw_rsp, 1'b0);
        check("mis_no_dmem_c2", a_dv, 1'b0);
        tick();
        check("mis_rsp_c2", saw_rsp, 1'b1);

        // Double size is illegal on a 32-bit bus.
        expect_rsp(32'h0, 1'b0, 1'b1, 1'b0);
        issue(1'b0, 2'b00, 1'b0, 32'h4000, 32'h0);
        check("ill_no_dmem", a_dv, 1'b0);
        tick();
        tick();
        check("ill_rsp_seen", saw_rsp, 1'b1);

        // Three back-to-back loads against two outstanding slots.
        expect_rsp(32'hFFFF_FFF3, 1'b0, 1'b0, 1'b0);
        expect_rsp(32'h0000_9876, 1'b0, 1'b0, 1'b0);
        expect_rsp(32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);
        issue(1'b0, 2'b11, 1'b0, 32'h5001, 32'h0);
        issue(1'b0, 2'b10, 1'b1, 32'h5002, 32'h0);
        a_req_valid = 1'b1; a_req_size = 2'b01; a_req_uns = 1'b0; a_req_addr = 32'h5004;
        check("l3_stall_0", a_req_ready, 1'b0);
        tick();
        check("l3_stall_1", a_req_ready, 1'b0);
        tick();
        check("l3_stall_2", a_req_ready, 1'b0);
        a_drv = 1'b1; a_drdata = 32'h1122_F344;
        check("l3_stall_rsp_cycle", a_req_ready, 1'b0);
        tick();
        a_drv = 1'b0;
        check("l3_ready_after_rsp", a_req_ready, 1'b1);
        tick();
        a_req_valid = 1'b0;
        check("l3_be", a_be, 4'b1111);
        check("l3_addr", a_daddr, 32'h5004);
        tick();
        respond(32'h9876_0000, 1'b0);
        respond(32'hCAFE_F00D, 1'b0);

        // Back-pressure: request held stable for five cycles.
        a_dr = 1'b0;
        issue(1'b1, 2'b11, 1'b0, 32'h6003, 32'h0000_00A5);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", a_dv, 1'b1);
            check("bp_addr", a_daddr, 32'h6000);
            check("bp_be", a_be, 4'b1000);
            check("bp_wdata", a_dwdata, 32'hA5A5_A5A5);
            check("bp_ready_low", a_req_ready, 1'b0);
            tick();
        end
        a_dr = 1'b1;
        expect_rsp(32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        respond(32'h0, 1'b0);

        // Bus error forces rdata to zero.
        issue(1'b0, 2'b01, 1'b0, 32'h7000, 32'h0);
        expect_rsp(32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        respond(32'h1234_5678, 1'b1);

        // Reset with a load outstanding: late response is dropped.
        issue(1'b0, 2'b01, 1'b0, 32'h8000, 32'h0);
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_dmem_valid", a_dv, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        respond(32'hFFFF_FFFF, 1'b0);
        check("rst_mid_rsp_dropped", saw_rsp, 1'b0);
        check("rst_mid_ready", a_req_ready, 1'b1);

        // 64-bit instance: double load and replicated byte store.
        b_req_valid = 1'b1; b_req_op = 1'b0; b_req_size = 2'b00; b_req_addr = 32'h10;
        check("d64_ready", b_req_ready, 1'b1);
        tick();
        b_req_valid = 1'b0;
        check("d64_addr", b_daddr, 32'h10);
        check("d64_be", b_be, 8'hFF);
        tick();
        b_drv = 1'b1; b_drdata = 64'h0123_4567_89AB_CDEF;
        #1;
        check("d64_rsp_valid", b_rsp_valid, 1'b1);
        check("d64_rdata", b_rsp_rdata, 64'h0123_4567_89AB_CDEF);
        tick();
        b_drv = 1'b0;
        b_req_valid = 1'b1; b_req_op = 1'b1; b_req_size = 2'b11; b_req_addr = 32'h15;
        b_req_wdata = 64'h5A;
        tick();
        b_req_valid = 1'b0;
        check("d64_sb_addr", b_daddr, 32'h10);
        check("d64_sb_be", b_be, 8'h20);
        check("d64_sb_wdata", b_dwdata, 64'h5A5A_5A5A_5A5A_5A5A);
        tick();
        b_drv = 1'b1; b_drdata = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        check("d64_sb_store", b_rsp_store, 1'b1);
        check("d64_sb_rdata", b_rsp_rdata, 64'h0);
        tick();
        b_drv = 1'b0;

        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ristretto_lsu_dmem_ctrl.md
Name: ristretto_lsu_dmem_ctrl

Overview:
- Parametrised load/store data-memory controller for the execution stage. Successor to the single-transaction idle/wait-ready/wait-valid data memory FSMs.
- Accepts one memory operation per cycle from the EXE control domain and generates byte enables and lane-aligned store data.
- Drives a valid/ready data-memory channel with up to MAX_OUTST in-order outstanding transactions.
- Returns sign/zero-extended load data and flags misaligned or illegal accesses as errors.

Parameters:
- DATA_W, 32, data bus width; legal values 32 or 64.
- ADDR_W, 32, address width.
- MAX_OUTST, 2, maximum accepted-but-unanswered memory transactions (1..8).
- OFF_W, $clog2(DATA_W/8), byte-offset bits; derived, not overridable.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  EXE request valid.
- req_ready_o  out  1  controller can accept request.
- req_op_i  in  1  0 = load, 1 = store.
- req_size_i  in  2  01 word, 10 half, 11 byte, 00 double (legal only when DATA_W=64).
- req_unsigned_i  in  1  1 = zero-extend load result.
- req_addr_i  in  ADDR_W  byte address.
- req_wdata_i  in  DATA_W  store data, right-aligned.
- rsp_valid_o  out  1  response valid; one-cycle pulse, no back-pressure.
- rsp_rdata_o  out  DATA_W  extended load data; 0 for stores and errors.
- rsp_store_o  out  1  response belongs to a store.
- rsp_err_o  out  1  bus error, misaligned access or illegal size.
- rsp_misaligned_o  out  1  error cause is misalignment.
- dmem_req_valid_o  out  1  memory request valid.
- dmem_req_ready_i  in  1  memory accepts request.
- dmem_we_o  out  1  write enable.
- dmem_addr_o  out  ADDR_W  address, with the low OFF_W bits forced to 0.
- dmem_be_o  out  DATA_W/8  byte enables.
- dmem_wdata_o  out  DATA_W  lane-replicated store data.
- dmem_rsp_valid_i  in  1  memory response valid.
- dmem_rdata_i  in  DATA_W  memory read data.
- dmem_rsp_err_i  in  1  memory bus error.

Behaviour:
- Reset values:
  - All outputs 0 except req_ready_o.
  - req_ready_o = 1 one cycle after reset release.
  - Outstanding count = 0; metadata FIFO empty; FSM in IDLE.
- Request FSM states:
  - IDLE: no request held.
  - WRDY: dmem request held, waiting for dmem_req_ready_i.
  - ERR: a local error response is pending.
- Acceptance and issue:
  - A request is accepted on req_valid_i && req_ready_o.
  - Accepted legal requests register onto the dmem_* outputs the next cycle (1-cycle issue latency); FSM goes to WRDY.
  - In WRDY, dmem_* outputs stay stable until the handshake.
  - On handshake, the FSM returns to IDLE, or stays in WRDY if a new request was accepted in the same cycle.
- req_ready_o = 1 when all of the following hold:
  - FSM is not ERR;
  - FSM is not in WRDY without dmem_req_ready_i;
  - count + (FSM==WRDY) < MAX_OUTST.
- Misalignment and illegal size:
  - Misaligned: half with addr[0]=1; word with addr[1:0]≠0; double with addr[2:0]≠0.
  - Illegal: size 00 when DATA_W=32.
  - Such requests generate no dmem transaction.
  - They are accepted only when count==0 and FSM==IDLE; otherwise req_ready_o is held low.
  - FSM goes to ERR, and the next cycle emits rsp_valid_o=1, rsp_err_o=1, rsp_misaligned_o=1 (0 for illegal size); FSM then returns to IDLE.
- Byte enables: size mask shifted left by addr[OFF_W-1:0].
- Store data: byte replicated into every lane; half into every 16-bit lane; word into every 32-bit lane.
- Outstanding tracking:
  - On each dmem handshake, {offset, size, unsigned, we} is pushed to a MAX_OUTST-entry FIFO and count increments.
  - dmem_rsp_valid_i pops the FIFO and decrements count.
  - A simultaneous handshake and response leaves count unchanged.
  - dmem_rsp_valid_i with the FIFO empty is ignored.
- Response:
  - Produced combinationally in the cycle dmem_rsp_valid_i is high.
  - Load data: dmem_rdata_i >> (offset*8), masked to size, then sign- or zero-extended to DATA_W.
  - rsp_err_o = dmem_rsp_err_i; rsp_rdata_o is forced to 0 on error.
  - rsp_store_o comes from the FIFO metadata.
- Reset mid-operation: all state clears immediately. Responses arriving after reset release with count==0 are dropped.

Test Plan:
- DATA_W=32, load byte addr 0x1003, signed, memory returns 0x80AB_CDEF:
  - be=1000, addr=0x1000;
  - rsp_rdata=0xFFFF_FF80 (0x0000_0080 when unsigned).
- Store half 0x1234_BEEF to 0x2002:
  - be=1100, wdata=0xBEEF_BEEF, we=1;
  - response rsp_store=1, rdata=0.
- Load word at 0x3001:
  - no dmem_req_valid_o;
  - exactly 2 cycles later rsp_valid=1, err=1, misaligned=1.
- MAX_OUTST=2, three back-to-back loads, dmem_req_ready_i=1, responses held off:
  - third load stalls (req_ready_o=0) until first response;
  - responses returned in order with correct extension.
- dmem_req_ready_i low for 5 cycles:
  - dmem_addr/be/wdata stable all 5 cycles;
  - req_ready_o=0 throughout.
- DATA_W=64, load double at 0x10 returning 0x0123_4567_89AB_CDEF:
  - be=0xFF, rdata unchanged;
  - size 00 with DATA_W=32 -> err=1, misaligned=0.
